// File: rtl/uart_cmd_parser.sv
// Streaming parser for ASCII "W <addr> <data>\r\n" / "R <addr>\r\n" frames.
// Optional macro UART_CMD_LOWER_HEX_EN also accepts 'w', 'r' and a-f.
module uart_cmd_parser #(
    parameter int ADDR_DIGITS = 4,
    parameter int DATA_DIGITS = 16
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [7:0]               RX_DATA,
    input  logic                     RX_VALID,
    output logic                     CMD_VALID,
    input  logic                     CMD_READY,
    output logic                     CMD_WRITE,
    output logic                     CMD_READ,
    output logic [4*ADDR_DIGITS-1:0] CMD_ADDR,
    output logic [4*DATA_DIGITS-1:0] CMD_DATA,
    output logic                     CMD_FAIL,
    output logic [2:0]               ERR_CODE,
    output logic                     OVERRUN
);

    localparam int AW         = 4 * ADDR_DIGITS;
    localparam int DW         = 4 * DATA_DIGITS;
    localparam int MAX_DIGITS = (ADDR_DIGITS > DATA_DIGITS) ? ADDR_DIGITS : DATA_DIGITS;
    localparam int CNT_W      = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_DIGITS - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_DIGITS - 1);

    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    localparam logic [2:0] ERR_NONE = 3'd0;
    localparam logic [2:0] ERR_OPC  = 3'd1;
    localparam logic [2:0] ERR_SEP  = 3'd2;
    localparam logic [2:0] ERR_HEX  = 3'd3;
    localparam logic [2:0] ERR_EOL  = 3'd4;

    typedef enum logic [3:0] {
        S_OPC, S_SP1, S_ADDR, S_SEP, S_DATA, S_CR, S_LF, S_SKIP, S_OUT
    } state_t;

    // Returns {valid, nibble}.
    function automatic logic [4:0] hex_decode(input logic [7:0] ch);
        logic [7:0] t;
        t = 8'h00;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            t = ch - 8'h30;
            return {1'b1, t[3:0]};
        end
        if (ch >= 8'h41 && ch <= 8'h46) begin
            t = ch - 8'h37;
            return {1'b1, t[3:0]};
        end
`ifdef UART_CMD_LOWER_HEX_EN
        if (ch >= 8'h61 && ch <= 8'h66) begin
            t = ch - 8'h57;
            return {1'b1, t[3:0]};
        end
`endif
        return 5'b0_0000;
    endfunction

    // Returns {valid, is_write}.
    function automatic logic [1:0] opc_decode(input logic [7:0] ch);
        if (ch == 8'h57) return 2'b11;
        if (ch == 8'h52) return 2'b10;
`ifdef UART_CMD_LOWER_HEX_EN
        if (ch == 8'h77) return 2'b11;
        if (ch == 8'h72) return 2'b10;
`endif
        return 2'b00;
    endfunction

    state_t           state_q, state_d;
    logic             is_write_q, is_write_d;
    logic [AW-1:0]    acc_addr_q, acc_addr_d;
    logic [DW-1:0]    acc_data_q, acc_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       err_q, err_d;
    logic             valid_q, valid_d, write_q, write_d, read_q, read_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    data_q, data_d;
    logic             fail_q, fail_d, overrun_q, overrun_d;
    logic [2:0]       code_q, code_d;

    logic [4:0] hex;
    logic [1:0] opc;
    logic       is_lf, go_skip, go_fail, go_good;
    logic [2:0] skip_code, fail_code;

    assign hex       = hex_decode(RX_DATA);
    assign opc       = opc_decode(RX_DATA);
    assign is_lf     = (RX_DATA == CH_LF);
    // A frame cut short by LF keeps its first recorded cause, else it is an end-of-line fault.
    assign fail_code = (err_q != ERR_NONE) ? err_q : ERR_EOL;

    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        acc_addr_d = acc_addr_q;
        acc_data_d = acc_data_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        valid_d    = valid_q;
        write_d    = write_q;
        read_d     = read_q;
        addr_d     = addr_q;
        data_d     = data_q;
        fail_d     = fail_q;
        code_d     = code_q;
        overrun_d  = 1'b0;
        go_skip    = 1'b0;
        go_fail    = 1'b0;
        go_good    = 1'b0;
        skip_code  = ERR_NONE;

        if (state_q == S_OUT) begin
            overrun_d = RX_VALID;
            if (CMD_READY) begin
                state_d = S_OPC;
                valid_d = 1'b0;
                write_d = 1'b0;
                read_d  = 1'b0;
                addr_d  = '0;
                data_d  = '0;
                fail_d  = 1'b0;
                code_d  = ERR_NONE;
                err_d   = ERR_NONE;
            end
        end else if (RX_VALID) begin
            case (state_q)
                S_OPC: begin
                    if (opc[1]) begin
                        is_write_d = opc[0];
                        state_d    = S_SP1;
                    end else if (!is_lf) begin
                        go_skip   = 1'b1;
                        skip_code = ERR_OPC;
                    end
                end
                S_SP1: begin
                    if (is_lf) go_fail = 1'b1;
                    else if (RX_DATA == CH_SP) begin
                        acc_addr_d = '0;
                        cnt_d      = '0;
                        state_d    = S_ADDR;
                    end else begin
                        go_skip   = 1'b1;
                        skip_code = ERR_SEP;
                    end
                end
                S_ADDR: begin
                    if (is_lf) go_fail = 1'b1;
                    else if (hex[4]) begin
                        acc_addr_d = (acc_addr_q << 4) | AW'(hex[3:0]);
                        cnt_d      = cnt_q + CNT_W'(1);
                        if (cnt_q == ADDR_LAST) state_d = S_SEP;
                    end else begin
                        go_skip   = 1'b1;
                        skip_code = ERR_HEX;
                    end
                end
                S_SEP: begin
                    if (is_lf) go_fail = 1'b1;
                    else if (is_write_q && RX_DATA == CH_SP) begin
                        acc_data_d = '0;
                        cnt_d      = '0;
                        state_d    = S_DATA;
                    end else if (!is_write_q && RX_DATA == CH_CR) begin
                        state_d = S_LF;
                    end else begin
                        go_skip   = 1'b1;
                        skip_code = is_write_q ? ERR_SEP : ERR_EOL;
                    end
                end
                S_DATA: begin
                    if (is_lf) go_fail = 1'b1;
                    else if (hex[4]) begin
                        acc_data_d = (acc_data_q << 4) | DW'(hex[3:0]);
                        cnt_d      = cnt_q + CNT_W'(1);
                        if (cnt_q == DATA_LAST) state_d = S_CR;
                    end else begin
                        go_skip   = 1'b1;
                        skip_code = ERR_HEX;
                    end
                end
                S_CR: begin
                    if (is_lf) go_fail = 1'b1;
                    else if (RX_DATA == CH_CR) state_d = S_LF;
                    else begin
                        go_skip   = 1'b1;
                        skip_code = ERR_EOL;
                    end
                end
                S_LF: begin
                    if (is_lf) go_good = 1'b1;
                    else begin
                        go_skip   = 1'b1;
                        skip_code = ERR_EOL;
                    end
                end
                S_SKIP: begin
                    if (is_lf) go_fail = 1'b1;
                end
                default: state_d = S_OPC;
            endcase
        end

        if (go_skip) begin
            state_d = S_SKIP;
            if (err_q == ERR_NONE) err_d = skip_code;
        end
        if (go_fail) begin
            state_d = S_OUT;
            valid_d = 1'b1;
            write_d = 1'b0;
            read_d  = 1'b0;
            addr_d  = '0;
            data_d  = '0;
            fail_d  = 1'b1;
            code_d  = fail_code;
        end
        if (go_good) begin
            state_d = S_OUT;
            valid_d = 1'b1;
            write_d = is_write_q;
            read_d  = !is_write_q;
            addr_d  = acc_addr_q;
            data_d  = is_write_q ? acc_data_q : '0;
            fail_d  = 1'b0;
            code_d  = ERR_NONE;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_OPC;
            is_write_q <= 1'b0;
            acc_addr_q <= '0;
            acc_data_q <= '0;
            cnt_q      <= '0;
            err_q      <= ERR_NONE;
            valid_q    <= 1'b0;
            write_q    <= 1'b0;
            read_q     <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            fail_q     <= 1'b0;
            code_q     <= ERR_NONE;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            acc_addr_q <= acc_addr_d;
            acc_data_q <= acc_data_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
            write_q    <= write_d;
            read_q     <= read_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            fail_q     <= fail_d;
            code_q     <= code_d;
            overrun_q  <= overrun_d;
        end
    end

    assign CMD_VALID = valid_q;
    assign CMD_WRITE = write_q;
    assign CMD_READ  = read_q;
    assign CMD_ADDR  = addr_q;
    assign CMD_DATA  = data_q;
    assign CMD_FAIL  = fail_q;
    assign ERR_CODE  = code_q;
    assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser at the default 4/16 digit configuration.
module tb_uart_cmd_parser;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [7:0]  RX_DATA = 8'h00;
    logic        RX_VALID = 1'b0;
    logic        CMD_READY = 1'b1;
    logic        CMD_VALID, CMD_WRITE, CMD_READ, CMD_FAIL, OVERRUN;
    logic [15:0] CMD_ADDR;
    logic [63:0] CMD_DATA;
    logic [2:0]  ERR_CODE;

    uart_cmd_parser #(.ADDR_DIGITS(4), .DATA_DIGITS(16)) dut (
        .CLK(CLK), .RST_N(RST_N), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_READ(CMD_READ), .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA),
        .CMD_FAIL(CMD_FAIL), .ERR_CODE(ERR_CODE), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        w;
        logic        r;
        logic [15:0] a;
        logic [63:0] d;
        logic        f;
        logic [2:0]  e;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   ovr_cnt = 0;
    logic post_hs = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        tick();
        RX_VALID = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic send_line(input string s);
        send_str(s);
        send_byte(8'h0D);
        send_byte(8'h0A);
        idle(3);
    endtask

    task automatic exp_w(input logic [15:0] a, input logic [63:0] d);
        exp_t e;
        e = '{w: 1'b1, r: 1'b0, a: a, d: d, f: 1'b0, e: 3'd0};
        sb.push_back(e);
    endtask

    task automatic exp_r(input logic [15:0] a);
        exp_t e;
        e = '{w: 1'b0, r: 1'b1, a: a, d: 64'h0, f: 1'b0, e: 3'd0};
        sb.push_back(e);
    endtask

    task automatic exp_fail(input logic [2:0] code);
        exp_t e;
        e = '{w: 1'b0, r: 1'b0, a: 16'h0, d: 64'h0, f: 1'b1, e: code};
        sb.push_back(e);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk(tag, {CMD_VALID, CMD_WRITE, CMD_READ, CMD_FAIL, OVERRUN, ERR_CODE, CMD_ADDR}, 0);
        chk({tag, "_data"}, CMD_DATA, 64'h0);
    endtask

    task automatic mon_step();
        exp_t e;
        if (post_hs) begin
            post_hs = 1'b0;
            chk("clear_ctl", {CMD_VALID, CMD_WRITE, CMD_READ, CMD_FAIL, ERR_CODE}, 0);
            chk("clear_addr", CMD_ADDR, 16'h0);
            chk("clear_data", CMD_DATA, 64'h0);
        end
        if (RST_N && CMD_VALID && CMD_READY) begin
            post_hs = 1'b1;
            if (sb.size() == 0) begin
                chk("unexpected_cmd", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("write", CMD_WRITE, e.w);
                chk("read", CMD_READ, e.r);
                chk("addr", CMD_ADDR, e.a);
                chk("data", CMD_DATA, e.d);
                chk("fail", CMD_FAIL, e.f);
                chk("err_code", ERR_CODE, e.e);
            end
        end
    endtask

    always @(negedge CLK) mon_step();

    always @(negedge CLK) if (OVERRUN) ovr_cnt <= ovr_cnt + 1;

    initial begin
        int o0;
        RST_N = 1'b0;
        idle(2);
        chk_idle_outputs("reset");
        RST_N = 1'b1;
        idle(2);

        exp_w(16'h12AB, 64'h0123456789ABCDEF);
        send_line("W 12AB 0123456789ABCDEF");
        exp_r(16'h00FF);
        send_line("R 00FF");

        exp_fail(3'd3);
        send_str("W 12G4 0000000000000000");
        chk("no_early_out", CMD_VALID, 1'b0);
        send_byte(8'h0D);
        send_byte(8'h0A);
        idle(3);

        exp_fail(3'd1);
        send_line("X 0000");
        exp_w(16'hFFFF, 64'hFFFFFFFFFFFFFFFF);
        send_line("W FFFF FFFFFFFFFFFFFFFF");
        exp_fail(3'd2);
        send_line("W 1234-0000000000000000");
        exp_fail(3'd4);
        send_str("R 00FF");
        send_byte(8'h0D);
        send_line("X");
        send_byte(8'h0A);
        exp_r(16'h1234);
        send_line("R 1234");

        // Consumer stalls; a byte arrives while the command is held.
        CMD_READY = 1'b0;
        exp_r(16'h00FF);
        send_line("R 00FF");
        for (int i = 0; i < 20 && !CMD_VALID; i++) tick();
        chk("stall_valid", CMD_VALID, 1'b1);
        o0 = ovr_cnt;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) send_byte("Z");
            else tick();
            chk("hold_ctl", {CMD_VALID, CMD_WRITE, CMD_READ, CMD_FAIL, ERR_CODE}, 7'b1010_000);
            chk("hold_addr", CMD_ADDR, 16'h00FF);
        end
        idle(1);
        chk("overrun_pulses", ovr_cnt - o0, 1);
        CMD_READY = 1'b1;
        idle(3);

        exp_fail(3'd4);
        send_str("W 12");
        send_byte(8'h0A);
        idle(3);
        exp_r(16'h0001);
        send_line("R 0001");

`ifdef UART_CMD_LOWER_HEX_EN
        exp_r(16'h00FF);
`else
        exp_fail(3'd1);
`endif
        send_line("r 00ff");

        // Reset while a command waits must clear it immediately.
        CMD_READY = 1'b0;
        send_line("R 0003");
        chk("pending_valid", CMD_VALID, 1'b1);
        RST_N = 1'b0;
        #1;
        chk_idle_outputs("reset_out");
        tick();
        RST_N = 1'b1;
        CMD_READY = 1'b1;
        idle(2);

        send_str("W 12");
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        tick();
        exp_r(16'h0002);
        send_line("R 0002");

        for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
        chk("drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
